btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//  Upstream stage for the mode-select FSM: turns a raw, bouncing push-button into clean events.
//  Provides a debounced level, one-cycle press/release pulses, a long-press pulse and a wrapping press counter.
//  press_pulse drives the FSM's mode-advance input directly, so the consumer needs no edge detector.
// PARAMETERS
//  DEBOUNCE_CYCLES    4    consecutive stable synced samples needed to accept a level change (>=1)
//  LONG_PRESS_CYCLES  256  cycles in PRESSED, counted from press_pulse, before long_pulse (>DEBOUNCE_CYCLES)
//  REPEAT_CYCLES      64   auto-repeat period in LONG_HELD (only used with BTN_AUTOREPEAT_EN, >=1)
// PORTS
//  clk            in   1  single clock domain, all logic on posedge
//  srst_n         in   1  synchronous reset, active-low
//  btn_raw        in   1  asynchronous, bouncing button input, active-high
//  btn_level      out  1  debounced button level
//  press_pulse    out  1  one-cycle strobe on accepted press (and on auto-repeat, if enabled)
//  release_pulse  out  1  one-cycle strobe on accepted release
//  long_pulse     out  1  one-cycle strobe when a hold reaches LONG_PRESS_CYCLES
//  press_count    out  8  number of press_pulse strobes, modulo 256
// BEHAVIOUR
//  - Reset (srst_n=0 at an edge): state=IDLE, synchronizer and all counters cleared.
//    All outputs are 0 after that edge. Reset overrides everything, including mid-debounce and mid-hold.
//  - Synchronizer: 2 flops, reset to 0. btn_s is btn_raw delayed by 2 edges; only btn_s is used by the FSM.
//  - States: IDLE, PRESS_WAIT, PRESSED, LONG_HELD. All outputs are registered.
//  - IDLE: btn_s=1 -> PRESS_WAIT with deb_cnt=1.
//  - PRESS_WAIT: btn_s=1 increments deb_cnt; btn_s=0 -> IDLE, deb_cnt=0 (bounce rejected, no output).
//    deb_cnt==DEBOUNCE_CYCLES -> PRESSED, press_pulse=1, btn_level=1, press_count+1, hold_cnt=0.
//  - Press latency: if btn_raw is first sampled 1 at edge k and held, press_pulse is high after edge
//    k+DEBOUNCE_CYCLES+2, for exactly one cycle.
//  - PRESSED: hold_cnt increments every cycle.
//    btn_s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE, release_pulse=1, btn_level=0.
//    A 1 sample during release debounce restarts rel_cnt; hold_cnt is not reset.
//    hold_cnt==LONG_PRESS_CYCLES -> LONG_HELD, long_pulse=1.
//  - LONG_HELD: same release rule as PRESSED, giving release_pulse=1 and IDLE.
//    long_pulse fires at most once per press.
//  - Simultaneous events: if release confirmation and the long threshold land on the same cycle, release wins.
//    release_pulse=1, long_pulse=0.
//  - Pulse exclusivity: press_pulse, release_pulse and long_pulse are never high in the same cycle.
//    btn_level changes only together with press_pulse or release_pulse.
//  - press_count wraps 255->0 silently. Counter widths are $clog2(max+1) of their parameter.
//    Counters saturate and never wrap inside a state.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//    - In LONG_HELD, rep_cnt counts and press_pulse fires every REPEAT_CYCLES cycles.
//    - First repeat comes REPEAT_CYCLES cycles after long_pulse; each repeat increments press_count.
//    - Release stops repeats immediately. A repeat due in the release-confirm cycle is suppressed.
//  BTN_AUTOREPEAT_EN undefined:
//    - LONG_HELD only waits for release. No repeat logic or rep_cnt flops are synthesized.
// TESTING  (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8)
//  1. srst_n=0 with btn_raw=1 for 5 cycles -> all outputs 0.
//     Release reset at edge 10 -> press_pulse after edge 16.
//  2. btn_raw=1 from edge 10 for 12 cycles, then 0 -> press_pulse only after edge 16; btn_level 1 from 16.
//     release_pulse once, 6 edges after the first 0 sample; press_count=1.
//  3. Bounce pattern 1,1,1,0,1,1,1,0,0,0,0,0 -> no pulses, btn_level stays 0, press_count=0.
//  4. Hold 40 cycles, macro off -> press_pulse at P, long_pulse at P+20, release_pulse on release.
//     No other pulses.
//  5. Same hold, macro on -> extra press_pulse at P+28 and P+36; press_count=3 after release.
//  6. 256 clean presses -> press_count back to 0.
//     srst_n=0 while in PRESSED -> outputs 0 next edge, no release_pulse.

Source files
------------

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Conditions a raw, bouncing, asynchronous push-button into clean,
//   single-cycle events for the mode-select FSM. It provides:
//   - a debounced level
//   - press, release and long-press strobes
//   - a wrapping 8-bit press counter
//
// Ports:
//   clk            in   1  single clock, all logic on posedge
//   srst_n         in   1  synchronous reset, active-low
//   btn_raw        in   1  asynchronous bouncing button input, active-high
//   btn_level      out  1  debounced button level
//   press_pulse    out  1  one-cycle strobe on accepted press (and auto-repeat)
//   release_pulse  out  1  one-cycle strobe on accepted release
//   long_pulse     out  1  one-cycle strobe when a hold reaches LONG_PRESS_CYCLES
//   press_count    out  8  number of press_pulse strobes, modulo 256
//
// Configuration macro:
//   BTN_AUTOREPEAT_EN - when defined, press_pulse repeats every REPEAT_CYCLES
//                       cycles while in LONG_HELD. When undefined, no repeat
//                       counter exists.
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 256,
  parameter int REPEAT_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  // The long threshold is taken on the edge where hold_cnt becomes
  // LONG_PRESS_CYCLES. That places long_pulse exactly LONG_PRESS_CYCLES
  // edges after press_pulse.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_LONG_HELD  = 2'd3;

  // Reject illegal parameter combinations at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_CYCLES < 1) begin : g_bad_params
    $error("btn_conditioner: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        sync_q;
  logic [1:0]        state_q,    state_d;
  logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
  logic [DEB_W-1:0]  rel_cnt_q,  rel_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q,    level_d;
  logic              press_q,    press_d;
  logic              release_q,  release_d;
  logic              long_q,     long_d;
  logic [7:0]        count_q,    count_d;
`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]  rep_cnt_q,  rep_cnt_d;
`endif

  logic btn_s;
  logic release_done;

  // Only the second synchronizer stage is ever looked at.
  assign btn_s = sync_q[1];

  // Release is confirmed on the sample after rel_cnt reached DEBOUNCE_CYCLES.
  // This mirrors the press path, so both have the same latency from btn_raw.
  assign release_done = !btn_s && (rel_cnt_q == DEB_MAX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    count_d    = count_q;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d   = ST_PRESS_WAIT;
          deb_cnt_d = DEB_W'(1);
        end else begin
          deb_cnt_d = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          level_d    = 1'b1;
          count_d    = count_q + 8'd1;
          hold_cnt_d = '0;
          rel_cnt_d  = '0;
          deb_cnt_d  = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      ST_PRESSED, ST_LONG_HELD: begin
        // Release debounce: any 1 sample restarts it. The counter
        // saturates until the confirming 0 sample arrives.
        if (btn_s) begin
          rel_cnt_d = '0;
        end else if (rel_cnt_q != DEB_MAX) begin
          rel_cnt_d = rel_cnt_q + DEB_W'(1);
        end

        if (release_done) begin
          // Release wins over a coincident long threshold or a repeat.
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          rel_cnt_d = '0;
          deb_cnt_d = '0;
        end else if (state_q == ST_PRESSED) begin
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_LONG_HELD;
            long_d  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_d = '0;
`endif
          end
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (rep_cnt_q == REP_LAST) begin
            press_d   = 1'b1;
            count_d   = count_q + 8'd1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      sync_q     <= '0;
      state_q    <= ST_IDLE;
      deb_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      count_q    <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      sync_q     <= {sync_q[0], btn_raw};
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      count_q    <= count_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule
